dec_output_serializer: RTL

Downstream companion to the pipelined decryption processor. Captures each completed 16-byte plaintext block (processor outputs w0..w15) into a two-slot ping-pong buffer and streams it out one byte per accepted beat over a valid/ready interface. The next block can be captured while the previous one is still draining, so the processor's block cadence is not stalled by a slow consumer.

---
 rtl/dec_pkg.sv | 34 +++
 rtl/dec_blk_buf2.sv | 61 ++++++
 rtl/dec_output_serializer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dec_pkg
//  Brief    : Shared definitions for the decryption output serializer:
//             block geometry, byte-index type, read FSM encoding and a
//             byte-extraction helper.
//  Revision : 1.0 - initial release
// ============================================================================
package dec_pkg;

    // Block geometry: sixteen bytes per plaintext block.
    localparam int BLK_BYTES = 16;
    localparam int BLK_BITS  = 8 * BLK_BYTES;

    // Byte index inside a block.
    typedef logic [3:0] byte_idx_t;

    localparam byte_idx_t c_IDX_LAST = 4'(BLK_BYTES - 1);

    // Read FSM encoding; PARITY is only reachable when the parity beat is built in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PARITY = 2'd2
    } rd_state_t;

    // Byte idx of a block; byte 0 sits in the least significant bits.
    function automatic logic [7:0] blk_byte(input logic [BLK_BITS-1:0] blk,
                                            input byte_idx_t            idx);
        return blk[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_blk_buf2.sv
`default_nettype none
// ============================================================================
//  Module   : dec_blk_buf2
//  Brief    : Two-slot ping-pong block buffer. Holds write pointer, read
//             pointer and occupancy. A push and a pop in the same cycle are
//             both honoured, even when both slots are occupied: the slot being
//             released is the one being overwritten.
//  Revision : 1.0 - initial release
// ============================================================================
module dec_blk_buf2
    import dec_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_push,
    input  logic [BLK_BITS-1:0] i_push_data,
    input  logic                i_pop,
    output logic [BLK_BITS-1:0] o_rd_data,
    output logic                o_full,
    output logic                o_empty
);

    logic [BLK_BITS-1:0] r_slot [2];
    logic                r_wp;
    logic                r_rp;
    logic [1:0]          r_cnt;

    // Slot storage; contents need no reset because occupancy decides validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_slot[r_wp] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (i_push) begin
                r_wp <= ~r_wp;
            end
            if (i_pop) begin
                r_rp <= ~r_rp;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_rd_data = r_slot[r_rp];
    assign o_full    = (r_cnt == 2'd2);
    assign o_empty   = (r_cnt == 2'd0);

endmodule
`default_nettype wire

// File: rtl/dec_output_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : dec_output_serializer
//  Brief    : Captures 16-byte plaintext blocks into a two-slot ping-pong
//             buffer and streams them out one byte per accepted beat over a
//             valid/ready interface, byte w0 first. Blocks arriving with both
//             slots busy are dropped and flagged by a sticky overflow.
//             Optional feature macro DEC_SER_PARITY_EN: appends a 17th beat
//             carrying the XOR of the 16 block bytes; dout_last then marks
//             that beat instead of byte 15.
//  Revision : 1.0 - initial release
// ============================================================================
module dec_output_serializer
    import dec_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                Enable,
    input  logic [BLK_BITS-1:0] blk_in,
    input  logic                blk_valid,
    output logic [7:0]          dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                busy,
    output logic                overflow
);

    rd_state_t           r_state;
    rd_state_t           w_state_nxt;
    byte_idx_t           r_idx;
    logic                r_overflow;

    logic [BLK_BITS-1:0] w_rd_data;
    logic                w_full;
    logic                w_empty;

    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_xfer;
    logic                w_idx_last;
    logic                w_more;
    logic [7:0]          w_byte;

    logic                w_dout_valid;
    logic [7:0]          w_dout;
    logic                w_dout_last;

    // A block is taken whenever a slot is free, counting one freed this cycle.
    assign w_push_req = Enable & blk_valid;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_xfer     = w_dout_valid & dout_ready;
    assign w_idx_last = (r_idx == c_IDX_LAST);
    assign w_byte     = blk_byte(w_rd_data, r_idx);
    // After the releasing beat another block is pending if the other slot was
    // already occupied or a new block is being captured right now.
    assign w_more     = w_full | w_push;

`ifdef DEC_SER_PARITY_EN
    logic [7:0] r_par;

    assign w_pop = w_xfer & (r_state == PARITY);

    // Running XOR of the bytes sent so far; restarts on byte 0 of each block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par <= 8'h00;
        end else if (w_xfer && (r_state == STREAM)) begin
            r_par <= ((r_idx == '0) ? 8'h00 : r_par) ^ w_byte;
        end
    end
`else
    assign w_pop = w_xfer & (r_state == STREAM) & w_idx_last;
`endif

    dec_blk_buf2 u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (blk_in),
        .i_pop       (w_pop),
        .o_rd_data   (w_rd_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next-state: enter STREAM in the capture cycle so byte 0 is
    // presented on the very next cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_push || (Enable && !w_empty)) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_xfer && w_idx_last) begin
`ifdef DEC_SER_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = w_more ? STREAM : IDLE;
`endif
                end
            end
`ifdef DEC_SER_PARITY_EN
            PARITY: begin
                if (w_xfer) begin
                    w_state_nxt = w_more ? STREAM : IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read FSM outputs: data only depends on state and index, so it holds
    // still while the consumer stalls.
    always_comb begin
        w_dout_valid = 1'b0;
        w_dout       = 8'h00;
        w_dout_last  = 1'b0;
        case (r_state)
            STREAM: begin
                w_dout_valid = Enable;
                w_dout       = w_byte;
`ifndef DEC_SER_PARITY_EN
                w_dout_last  = w_idx_last;
`endif
            end
`ifdef DEC_SER_PARITY_EN
            PARITY: begin
                w_dout_valid = Enable;
                w_dout       = r_par;
                w_dout_last  = 1'b1;
            end
`endif
            default: begin
                w_dout_valid = 1'b0;
            end
        endcase
    end

    // Byte index advances on every accepted data beat and wraps after byte 15.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_xfer && (r_state == STREAM)) begin
            r_idx <= r_idx + 4'd1;
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && !w_push) begin
            r_overflow <= 1'b1;
        end
    end

    assign dout       = w_dout;
    assign dout_valid = w_dout_valid;
    assign dout_last  = w_dout_last;
    assign busy       = ~w_empty;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
